regbank_dump_reader: RTL and testbench

Debug-side reader for the register bank's debug read port. On a start pulse it walks every register address from 0 to 2^addr_bits-1 and captures each word. It then serializes each word into bytes, MSB first, and hands them to the debug UART transmitter over a valid/ready byte handshake. It sits in the debug unit, between the register bank's debug read port and the UART TX.

---
 rtl/regbank_dump_reader_pkg.sv | 22 ++
 rtl/regbank_dump_reader_word_byte_serializer.sv | 63 ++++++
 rtl/regbank_dump_reader.sv | 86 ++++++++
 tb/tb_regbank_dump_reader.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/regbank_dump_reader_pkg.sv
// Shared debug-path definitions: dump FSM states, byte width and the
// per-word / per-bank derivations used by the dump reader and UART TX.
package regbank_dump_reader_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SEND,
        ST_DONE
    } dump_state_e;

    function automatic int unsigned bytes_per_word(input int unsigned word_bits);
        return word_bits / BYTE_W;
    endfunction

    function automatic int unsigned last_addr(input int unsigned addr_width);
        return (32'd1 << addr_width) - 32'd1;
    endfunction

endpackage

// File: rtl/regbank_dump_reader_word_byte_serializer.sv
// Load/shift register that presents a captured word MSB byte first over a
// valid/ready handshake and flags acceptance of the final byte.
module regbank_dump_reader_word_byte_serializer
    import regbank_dump_reader_pkg::*;
#(
    parameter int unsigned word_wide = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load_i,
    input  logic [word_wide-1:0] word_i,
    input  logic                 ready_i,
    output logic [BYTE_W-1:0]    data_o,
    output logic                 valid_o,
    output logic                 last_accept_o
);

    localparam int unsigned     BYTES    = bytes_per_word(word_wide);
    localparam int unsigned     CNT_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES - 1);

    logic [word_wide-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 valid_q, valid_d;
    logic                 accept;

    assign accept        = valid_q && ready_i;
    assign last_accept_o = accept && (cnt_q == LAST_CNT);
    // The top byte of the shift register is the registered txData.
    assign data_o        = shift_q[word_wide-1 -: BYTE_W];
    assign valid_o       = valid_q;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (load_i) begin
            shift_d = word_i;
            cnt_d   = '0;
            valid_d = 1'b1;
        end else if (accept) begin
            if (cnt_q == LAST_CNT) begin
                valid_d = 1'b0;
            end else begin
                shift_d = shift_q << BYTE_W;
                cnt_d   = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/regbank_dump_reader.sv
// Walks every register-bank address on a start pulse, snapshots each word and
// streams it to the debug UART TX as bytes, MSB first, ascending address.
module regbank_dump_reader
    import regbank_dump_reader_pkg::*;
#(
    parameter int unsigned addr_bits = 5,
    parameter int unsigned word_wide = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    output logic [addr_bits-1:0] readRegFromDebug,
    input  logic [word_wide-1:0] readDataToDebug,
    output logic [BYTE_W-1:0]    txData,
    output logic                 txValid,
    input  logic                 txReady,
    output logic                 busy,
    output logic                 done
);

    localparam logic [addr_bits-1:0] LAST_ADDR = addr_bits'(last_addr(addr_bits));

    dump_state_e          state_q, state_d;
    logic [addr_bits-1:0] addr_q, addr_d;
    logic                 load;
    logic                 last_accept;

    regbank_dump_reader_word_byte_serializer #(
        .word_wide(word_wide)
    ) u_serializer (
        .clock        (clock),
        .reset        (reset),
        .load_i       (load),
        .word_i       (readDataToDebug),
        .ready_i      (txReady),
        .data_o       (txData),
        .valid_o      (txValid),
        .last_accept_o(last_accept)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        load    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d  = '0;
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                // Address was registered last cycle, so bank data is settled.
                load    = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (last_accept) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = ST_LATCH;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    assign readRegFromDebug = addr_q;
    assign busy             = (state_q != ST_IDLE);
    assign done             = (state_q == ST_DONE);

endmodule

// File: tb/tb_regbank_dump_reader.sv
// Directed bench for regbank_dump_reader: full dump, backpressure, ignored
// restart, snapshot, mid-dump reset and reset/start collision.
module tb_regbank_dump_reader;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  readRegFromDebug;
    logic [31:0] readDataToDebug;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady;
    logic        busy;
    logic        done;

    logic [31:0] bank [32];
    logic [7:0]  hs_q [$];
    int          checks = 0;
    int          failures = 0;
    int          rel = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          last_hs = 0;
    logic        busy_at_done = 1'b0;

    regbank_dump_reader #(
        .addr_bits(5),
        .word_wide(32)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .readRegFromDebug(readRegFromDebug),
        .readDataToDebug (readDataToDebug),
        .txData          (txData),
        .txValid         (txValid),
        .txReady         (txReady),
        .busy            (busy),
        .done            (done)
    );

    always #5 clock = ~clock;

    assign readDataToDebug = bank[readRegFromDebug];

    // Mid-cycle monitor: a byte counts when valid and ready are both high.
    always @(negedge clock) begin
        if (txValid && txReady) begin
            hs_q.push_back(txData);
            last_hs = rel;
        end
        if (done) begin
            done_cnt++;
            done_cyc = rel;
            busy_at_done = busy;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
        return 8'(w >> (8 * (3 - k)));
    endfunction

    // mode 0: txReady held high; mode 1: txReady pattern 1-0-0.
    task automatic run(input int mode, input int start2_at, input int wr_at,
                       input int rst_at, input int max_cyc);
        logic       stall_prev;
        logic [7:0] prev_data;
        hs_q.delete();
        done_cnt   = 0;
        done_cyc   = 0;
        last_hs    = 0;
        stall_prev = 1'b0;
        prev_data  = '0;
        txReady    = 1'b1;
        start      = 1'b1;
        @(posedge clock); #1;
        rel = 1;
        while (rel <= max_cyc) begin
            if (stall_prev) begin
                chk($sformatf("stall_valid_c%0d", rel), txValid, 1'b1);
                chk($sformatf("stall_data_c%0d", rel), txData, prev_data);
            end
            if (done_cnt > 0 && rel > done_cyc) break;
            txReady = (mode == 0) || (rel % 3 == 1);
            start   = (rel == start2_at);
            reset   = (rel == rst_at);
            if (rel == wr_at) bank[3] = 32'hFFFF_FFFF;
            stall_prev = txValid && !txReady;
            prev_data  = txData;
            @(posedge clock); #1;
            if (reset) return;
            rel++;
        end
        start   = 1'b0;
        txReady = 1'b1;
    endtask

    task automatic check_stream(input string tag, input int special_reg,
                                input logic [31:0] special_word);
        logic [31:0] w;
        chk({tag, "_count"}, hs_q.size(), 128);
        for (int i = 0; i < 128 && i < hs_q.size(); i++) begin
            w = (i / 4 == special_reg) ? special_word : 32'h0100_0000 + i / 4;
            chk($sformatf("%s_byte%0d", tag, i), hs_q[i], byte_of(w, i % 4));
        end
        chk({tag, "_done_count"}, done_cnt, 1);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        txReady = 1'b1;
        for (int n = 0; n < 32; n++) bank[n] = 32'h0100_0000 + n;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_txValid", txValid, 1'b0);
        chk("rst_txData", txData, 8'h00);
        chk("rst_addr", readRegFromDebug, 5'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        run(0, 0, 0, 0, 400);
        check_stream("plain", -1, 32'h0);
        chk("plain_last_hs_cycle", last_hs, 160);
        chk("plain_done_cycle", done_cyc, 161);
        chk("plain_busy_at_done", busy_at_done, 1'b1);
        chk("plain_busy_after_done", busy, 1'b0);
        chk("plain_done_after", done, 1'b0);

        bank[5] = 32'hDEAD_BEEF;
        run(1, 0, 0, 0, 1500);
        check_stream("stall", 5, 32'hDEAD_BEEF);
        bank[5] = 32'h0100_0005;

        run(0, 20, 17, 0, 400);
        check_stream("snap_restart", -1, 32'h0);
        chk("snap_restart_done_cycle", done_cyc, 161);
        bank[3] = 32'h0100_0003;

        run(0, 0, 0, 39, 400);
        chk("midrst_txValid", txValid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_addr", readRegFromDebug, 5'd0);
        chk("midrst_txData", txData, 8'h00);
        chk("midrst_done", done, 1'b0);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("midrst_no_done", done_cnt, 0);
        run(0, 0, 0, 0, 400);
        check_stream("after_rst", -1, 32'h0);

        start = 1'b1;
        reset = 1'b1;
        @(posedge clock); #1;
        chk("collide_busy", busy, 1'b0);
        start = 1'b0;
        reset = 1'b0;
        @(posedge clock); #1;
        chk("collide_busy_next", busy, 1'b0);
        chk("collide_txValid", txValid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
